axil_slave_regs: RTL
====================

AXIL_SLAVE_REGS -- requirements
Module: axil_slave_regs

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_4000, byte address of register 0.
REQ-002 SHALL have parameter NREGS, default 8, number of read/write registers (2..16).
REQ-003 SHALL have port aclk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port areset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_awaddr/s_awvalid/s_awready  in/in/out  32/1/1  write-address channel.
REQ-006 SHALL have port s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  32/4/1/1  write-data channel.
REQ-007 SHALL have port s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  write-response channel.
REQ-008 SHALL have port s_araddr/s_arvalid/s_arready  in/in/out  32/1/1  read-address channel.
REQ-009 SHALL have port s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  32/2/1/1  read-data channel.
REQ-010 SHALL have port sts_i  input  32  hardware status, read-only at BASE_ADDR+4*NREGS.
REQ-011 SHALL have port reg_q  output  32*NREGS  flat register contents, register k at bits [32k+31:32k].
REQ-012 SHALL have port reg_wr  output  NREGS  one-cycle pulse per register written.

Function
REQ-013 Write FSM SHALL have states W_IDLE, W_GOTA (address held), W_GOTD (data held), W_RESP.
REQ-014 s_awready SHALL be 1 in W_IDLE and W_GOTD; s_wready SHALL be 1 in W_IDLE and W_GOTA; both 0 in W_RESP.
REQ-015 AW-only handshake SHALL go W_IDLE->W_GOTA; W-only SHALL go W_IDLE->W_GOTD; both in same cycle, or the missing half from W_GOTA/W_GOTD, SHALL go to W_RESP.
REQ-016 Register update SHALL occur on the clock edge entering W_RESP, per byte lane where s_wstrb[i]=1; reg_wr[k] SHALL pulse in the following cycle only.
REQ-017 s_bvalid SHALL be 1 exactly in W_RESP; W_RESP->W_IDLE when s_bready=1; bvalid held stable until accepted.
REQ-018 Read FSM SHALL have states R_IDLE (s_arready=1) and R_RESP (s_rvalid=1, s_arready=0); s_rdata/s_rresp registered on AR handshake; R_RESP->R_IDLE when s_rready=1.
REQ-019 Word index SHALL be (addr-BASE_ADDR)>>2 in 32-bit arithmetic; addr[1:0] ignored; addresses below BASE_ADDR wrap to a huge index and count as unmapped.
REQ-020 Index NREGS SHALL read sts_i sampled at AR handshake; writes to it SHALL be discarded with OKAY response.
REQ-021 Read and write to same register committing on same edge SHALL return the pre-write value.
REQ-022 Read and write channels SHALL operate independently and concurrently; no outstanding-transaction depth beyond one per channel.

Reset
REQ-023 On areset_n=0, asynchronously: both FSMs idle, all reg_q=0, reg_wr=0, s_bvalid=0, s_rvalid=0, s_bresp=0, s_rresp=0, s_rdata=0, s_awready=1, s_wready=1, s_arready=1 (high from reset).
REQ-024 Reset mid-transaction SHALL abandon it; no partial register update survives; held responses SHALL drop immediately.

Configuration
REQ-025 Macro AXIL_SLAVE_DECERR_EN defined: unmapped index (>NREGS) SHALL return s_bresp/s_rresp=2'b11 (DECERR), s_rdata=0, no register change.
REQ-026 Macro undefined: unmapped accesses SHALL return 2'b00 (OKAY), reads 0, writes discarded.

Structure
REQ-027 Package axil_pkg SHALL hold axil_resp_e (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), wr_state_e, rd_state_e and the UART register offset constants shared with the master/bridge side.
REQ-028 Address-to-index decode and hit/miss SHALL live in sub-module axil_addr_dec, instantiated once per channel.

Verification
REQ-029 AW+W same cycle addr=0x4004 data=0xDEADBEEF strb=4'hF, bready=1 -> bvalid next cycle, bresp=0, reg_q[63:32]=0xDEADBEEF, reg_wr=8'h02 one cycle.
REQ-030 W three cycles before AW (addr 0x4000, data 0x11223344, strb 4'b0101) after reg0=0xFFFFFFFF -> reg0=0xFF22FF44; bvalid only after AW.
REQ-031 Read addr 0x4020 with sts_i=0xA5A5_0001 and rready low 5 cycles -> rvalid held, rdata stable 0xA5A50001, arready=0 until accepted.
REQ-032 Read/write 0x4100 -> DECERR and rdata=0 with AXIL_SLAVE_DECERR_EN; OKAY and rdata=0 without; reg_q unchanged either way.
REQ-033 Simultaneous write 0x55 and read reg2 (old 0x33) -> rdata=0x33, reg2=0x55 afterward.
REQ-034 areset_n low while bvalid=1 awaiting bready -> bvalid=0 same cycle asynchronously, all reg_q=0, ready signals 1 after release.

Source files
------------

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axil_pkg
// Brief    : AXI-Lite response codes, slave FSM state types and UART map.
// Revision : 1.0 - initial release
// ============================================================================
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_GOTA = 2'd1,
        W_GOTD = 2'd2,
        W_RESP = 2'd3
    } wr_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_e;

    // UART register byte offsets, shared with the master/bridge side
    localparam logic [31:0] UART_RBR_OFF = 32'h0000_0000;
    localparam logic [31:0] UART_THR_OFF = 32'h0000_0004;
    localparam logic [31:0] UART_IER_OFF = 32'h0000_0008;
    localparam logic [31:0] UART_LCR_OFF = 32'h0000_000C;
    localparam logic [31:0] UART_LSR_OFF = 32'h0000_0010;
    localparam logic [31:0] UART_DIV_OFF = 32'h0000_0014;
    localparam logic [31:0] UART_SCR_OFF = 32'h0000_0018;

endpackage
`default_nettype wire

// File: rtl/axil_addr_dec.sv
`default_nettype none
// ============================================================================
// Module   : axil_addr_dec
// Brief    : Byte address to register word index with hit / status decode.
// Revision : 1.0 - initial release
// ============================================================================
module axil_addr_dec #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
    parameter int          NREGS     = 8,
    parameter int          IDX_W     = 3
) (
    input  logic [31:0]      addr,
    output logic [IDX_W-1:0] idx,
    output logic             hit,
    output logic             sts
);

    logic [31:0] w_word;

    // Addresses below the base wrap to a huge index and fall out as misses
    assign w_word = (addr - BASE_ADDR) >> 2;
    assign hit    = (w_word < 32'(NREGS));
    assign sts    = (w_word == 32'(NREGS));
    assign idx    = w_word[IDX_W-1:0];

endmodule
`default_nettype wire

// File: rtl/axil_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : axil_slave_regs
// Brief    : AXI-Lite slave with NREGS R/W registers and one read-only status
//            word. Define AXIL_SLAVE_DECERR_EN to answer unmapped accesses
//            with DECERR instead of OKAY.
// Revision : 1.0 - initial release
// ============================================================================
module axil_slave_regs
    import axil_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
    parameter int          NREGS     = 8
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic [31:0]           s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [31:0]           s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    input  logic [31:0]           sts_i,
    output logic [32*NREGS-1:0]   reg_q,
    output logic [NREGS-1:0]      reg_wr
);

    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

`ifdef AXIL_SLAVE_DECERR_EN
    localparam axil_resp_e MISS_RESP = DECERR;
`else
    localparam axil_resp_e MISS_RESP = OKAY;
`endif

    wr_state_e        r_wstate, w_wnext;
    rd_state_e        r_rstate, w_rnext;
    logic [31:0]      r_regs [NREGS];
    logic [31:0]      r_awaddr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wstrb;
    axil_resp_e       r_bresp;
    axil_resp_e       r_rresp;
    logic [31:0]      r_rdata;

    logic             w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [31:0]      w_wr_addr, w_wr_data;
    logic [3:0]       w_wr_strb;
    logic [IDX_W-1:0] w_wr_idx, w_rd_idx;
    logic             w_wr_hit, w_wr_sts, w_rd_hit, w_rd_sts;

    assign w_aw_hs = s_awvalid && s_awready;
    assign w_w_hs  = s_wvalid && s_wready;
    assign w_ar_hs = s_arvalid && s_arready;

    // The half that arrived earlier comes from the holding registers
    assign w_wr_addr = (r_wstate == W_GOTA) ? r_awaddr : s_awaddr;
    assign w_wr_data = (r_wstate == W_GOTD) ? r_wdata  : s_wdata;
    assign w_wr_strb = (r_wstate == W_GOTD) ? r_wstrb  : s_wstrb;
    assign w_commit  = (r_wstate != W_RESP) && (w_wnext == W_RESP);

    axil_addr_dec #(.BASE_ADDR(BASE_ADDR), .NREGS(NREGS), .IDX_W(IDX_W)) u_wr_dec (
        .addr (w_wr_addr),
        .idx  (w_wr_idx),
        .hit  (w_wr_hit),
        .sts  (w_wr_sts)
    );

    axil_addr_dec #(.BASE_ADDR(BASE_ADDR), .NREGS(NREGS), .IDX_W(IDX_W)) u_rd_dec (
        .addr (s_araddr),
        .idx  (w_rd_idx),
        .hit  (w_rd_hit),
        .sts  (w_rd_sts)
    );

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) r_wstate <= W_IDLE;
        else           r_wstate <= w_wnext;
    end

    always_comb begin
        w_wnext = r_wstate;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) w_wnext = W_RESP;
                else if (w_aw_hs)      w_wnext = W_GOTA;
                else if (w_w_hs)       w_wnext = W_GOTD;
            end
            W_GOTA:  if (w_w_hs)   w_wnext = W_RESP;
            W_GOTD:  if (w_aw_hs)  w_wnext = W_RESP;
            W_RESP:  if (s_bready) w_wnext = W_IDLE;
            default: w_wnext = W_IDLE;
        endcase
    end

    always_comb begin
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        case (r_wstate)
            W_IDLE:  begin s_awready = 1'b1; s_wready = 1'b1; end
            W_GOTA:  s_wready  = 1'b1;
            W_GOTD:  s_awready = 1'b1;
            W_RESP:  s_bvalid  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= OKAY;
        end else begin
            if (w_aw_hs) r_awaddr <= s_awaddr;
            if (w_w_hs) begin
                r_wdata <= s_wdata;
                r_wstrb <= s_wstrb;
            end
            if (w_commit) r_bresp <= (!w_wr_hit && !w_wr_sts) ? MISS_RESP : OKAY;
        end
    end

    assign s_bresp = r_bresp;

    for (genvar k = 0; k < NREGS; k++) begin : g_reg
        logic w_sel;
        logic r_pulse;

        assign w_sel = w_commit && w_wr_hit && (w_wr_idx == IDX_W'(k));

        always_ff @(posedge aclk or negedge areset_n) begin
            if (!areset_n) begin
                r_regs[k] <= '0;
                r_pulse   <= 1'b0;
            end else begin
                r_pulse <= w_sel;
                if (w_sel) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_wr_strb[b]) r_regs[k][8*b +: 8] <= w_wr_data[8*b +: 8];
                    end
                end
            end
        end

        assign reg_q[32*k +: 32] = r_regs[k];
        assign reg_wr[k]         = r_pulse;
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) r_rstate <= R_IDLE;
        else           r_rstate <= w_rnext;
    end

    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE:  if (s_arvalid) w_rnext = R_RESP;
            R_RESP:  if (s_rready)  w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    always_comb begin
        s_arready = (r_rstate == R_IDLE);
        s_rvalid  = (r_rstate == R_RESP);
    end

    // Sampled on the AR edge, so a same-edge write is not yet visible
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_rdata <= '0;
            r_rresp <= OKAY;
        end else if (w_ar_hs) begin
            if (w_rd_hit)      r_rdata <= r_regs[w_rd_idx];
            else if (w_rd_sts) r_rdata <= sts_i;
            else               r_rdata <= '0;
            r_rresp <= (!w_rd_hit && !w_rd_sts) ? MISS_RESP : OKAY;
        end
    end

    assign s_rdata = r_rdata;
    assign s_rresp = r_rresp;

endmodule
`default_nettype wire
